// File: rtl/pa_dcache_tag_ctrl_if.sv
// Signal bundle for the D-cache tag controller: invalidate sweep, lookup, tag write and response.
interface pa_dcache_tag_ctrl_if #(
    parameter int WAYS      = 2,
    parameter int TAG_LEN   = 21,
    parameter int INDEX_LEN = 7
);
    logic                           inv_all_req;
    logic                           inv_busy;
    logic                           rd_vld;
    logic                           rd_rdy;
    logic [INDEX_LEN-1:0]           rd_idx;
    logic [TAG_LEN-1:0]             rd_tag;
    logic                           wr_vld;
    logic [INDEX_LEN-1:0]           wr_idx;
    logic [WAYS-1:0]                wr_way;
    logic [TAG_LEN-1:0]             wr_tag;
    logic                           wr_valid;
    logic                           rsp_vld;
    logic [WAYS-1:0]                rsp_hit;
    logic [WAYS*(TAG_LEN+1)-1:0]    rsp_tags;
    logic [WAYS-1:0]                par_err;

    modport master (
        output inv_all_req, rd_vld, rd_idx, rd_tag, wr_vld, wr_idx, wr_way, wr_tag, wr_valid,
        input  inv_busy, rd_rdy, rsp_vld, rsp_hit, rsp_tags, par_err
    );

    modport slave (
        input  inv_all_req, rd_vld, rd_idx, rd_tag, wr_vld, wr_idx, wr_way, wr_tag, wr_valid,
        output inv_busy, rd_rdy, rsp_vld, rsp_hit, rsp_tags, par_err
    );
endinterface

// File: rtl/pa_dcache_tag_ctrl.sv
// D-cache tag array with lookup, write-to-response forwarding and a full invalidate sweep.
// Optional per-way even parity over {valid, tag} is enabled by defining D_TAG_PARITY_EN.
module pa_dcache_tag_ctrl #(
    parameter int WAYS      = 2,
    parameter int TAG_LEN   = 21,
    parameter int INDEX_LEN = 7
) (
    input logic                 forever_cpuclk,
    input logic                 cpurst_b,
    pa_dcache_tag_ctrl_if.slave bus
);
    localparam int DEPTH = 1 << INDEX_LEN;
    localparam int ENT_W = TAG_LEN + 1;

    typedef enum logic {IDLE, INV} state_e;

    state_e               state_q, state_d;
    logic [INDEX_LEN-1:0] cnt_q, cnt_d;
    logic                 boot_q;
    logic                 sweep_start;
    logic                 sweeping;
    logic                 wr_en;
    logic                 rd_acc;

    logic [ENT_W-1:0]     tag_mem_q [WAYS][DEPTH];
`ifdef D_TAG_PARITY_EN
    logic                 par_mem_q [WAYS][DEPTH];
`endif

    logic                 rsp_vld_q;
    logic [INDEX_LEN-1:0] ridx_q;
    logic [TAG_LEN-1:0]   rtag_q;
    logic [WAYS*ENT_W-1:0] hold_tags_q;
    logic [WAYS-1:0]      hold_hit_q;

    logic [WAYS*ENT_W-1:0] live_tags;
    logic [WAYS-1:0]      live_hit;
    logic [WAYS-1:0]      live_perr;
    logic [WAYS-1:0]      fwd;

    // boot_q forces one sweep right after reset so no lookup ever sees stale valid bits
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            boot_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            boot_q  <= 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sweep_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (boot_q || bus.inv_all_req) begin
                    state_d     = INV;
                    cnt_d       = '0;
                    sweep_start = 1'b1;
                end
            end
            INV: begin
                cnt_d = cnt_q + INDEX_LEN'(1);
                if (&cnt_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign sweeping     = (state_q == INV);
    assign bus.inv_busy = sweeping;
    assign bus.rd_rdy   = !sweeping && !bus.wr_vld;
    assign wr_en        = bus.wr_vld && !sweeping && !sweep_start;
    assign rd_acc       = bus.rd_vld && bus.rd_rdy;

    // Tag storage carries no reset; the sweep establishes a known valid state.
    always_ff @(posedge forever_cpuclk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (sweeping) begin
                tag_mem_q[w][cnt_q][TAG_LEN] <= 1'b0;
`ifdef D_TAG_PARITY_EN
                par_mem_q[w][cnt_q] <= ^tag_mem_q[w][cnt_q][TAG_LEN-1:0];
`endif
            end else if (wr_en && bus.wr_way[w]) begin
                tag_mem_q[w][bus.wr_idx] <= {bus.wr_valid, bus.wr_tag};
`ifdef D_TAG_PARITY_EN
                par_mem_q[w][bus.wr_idx] <= ^{bus.wr_valid, bus.wr_tag};
`endif
            end
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (rd_acc) begin
            ridx_q <= bus.rd_idx;
            rtag_q <= bus.rd_tag;
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rsp_vld_q   <= 1'b0;
            hold_tags_q <= '0;
            hold_hit_q  <= '0;
        end else begin
            rsp_vld_q <= rd_acc;
            if (rsp_vld_q) begin
                hold_tags_q <= live_tags;
                hold_hit_q  <= live_hit;
            end
        end
    end

    // A write landing on the responding index overrides the array read for its ways.
    always_comb begin
        live_tags = '0;
        live_hit  = '0;
        live_perr = '0;
        fwd       = '0;
        for (int w = 0; w < WAYS; w++) begin
            fwd[w] = wr_en && bus.wr_way[w] && (bus.wr_idx == ridx_q);
            live_tags[w*ENT_W +: ENT_W] = fwd[w] ? {bus.wr_valid, bus.wr_tag} : tag_mem_q[w][ridx_q];
`ifdef D_TAG_PARITY_EN
            live_perr[w] = !fwd[w] && (par_mem_q[w][ridx_q] != ^tag_mem_q[w][ridx_q]);
`endif
            live_hit[w] = live_tags[w*ENT_W + TAG_LEN]
                          && (live_tags[w*ENT_W +: TAG_LEN] == rtag_q)
                          && !live_perr[w];
        end
    end

    assign bus.rsp_vld  = rsp_vld_q;
    assign bus.rsp_tags = rsp_vld_q ? live_tags : hold_tags_q;
    assign bus.rsp_hit  = rsp_vld_q ? live_hit  : hold_hit_q;
    assign bus.par_err  = rsp_vld_q ? live_perr : '0;
endmodule

// File: tb/tb_pa_dcache_tag_ctrl.sv
// Self-checking bench for pa_dcache_tag_ctrl: vector table, scoreboard-checked lookups, sweep/forwarding sequences.
module tb_pa_dcache_tag_ctrl;
    localparam int WAYS = 2, TAG_LEN = 21, INDEX_LEN = 7, DEPTH = 128, ENT_W = 22;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pa_dcache_tag_ctrl_if #(.WAYS(WAYS), .TAG_LEN(TAG_LEN), .INDEX_LEN(INDEX_LEN)) bus ();

    pa_dcache_tag_ctrl #(.WAYS(WAYS), .TAG_LEN(TAG_LEN), .INDEX_LEN(INDEX_LEN)) dut (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_n),
        .bus            (bus)
    );

    typedef struct {
        logic [6:0]  idx;
        logic [20:0] tag;
        logic [1:0]  hit;
        logic [1:0]  perr;
    } exp_t;

    typedef struct {
        bit          is_wr;
        logic [6:0]  idx;
        logic [1:0]  way;
        logic [20:0] tag;
        logic        v;
        logic [1:0]  hit;
    } vec_t;

    int          n_pass  = 0;
    int          n_total = 0;
    bit          mon_en  = 1'b0;
    logic [1:0]  nxt_hit  = 2'b00;
    logic [1:0]  nxt_perr = 2'b00;
    logic [ENT_W-1:0] model [WAYS][DEPTH];
    exp_t        sb[$];
    exp_t        mon_e;
    exp_t        push_e;
    logic [43:0] exp_tags, tag_mask;
    vec_t        vecs [13];
    int          cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference model and scoreboard, evaluated mid-cycle while inputs and outputs are stable.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.wr_vld && !bus.inv_busy && !bus.inv_all_req)
                for (int w = 0; w < WAYS; w++)
                    if (bus.wr_way[w]) model[w][bus.wr_idx] = {bus.wr_valid, bus.wr_tag};
            if (bus.rsp_vld) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL rsp_unexpected: got rsp_vld=1 expected no response");
                end else begin
                    mon_e = sb.pop_front();
                    exp_tags = '0;
                    tag_mask = '0;
                    for (int w = 0; w < WAYS; w++) begin
                        if (model[w][mon_e.idx][TAG_LEN]) begin
                            exp_tags[w*ENT_W +: ENT_W] = model[w][mon_e.idx];
                            tag_mask[w*ENT_W +: ENT_W] = '1;
                        end else begin
                            tag_mask[w*ENT_W + TAG_LEN] = 1'b1;
                        end
                    end
                    check($sformatf("rsp_hit idx%0d", mon_e.idx), 64'(bus.rsp_hit), 64'(mon_e.hit));
                    check($sformatf("par_err idx%0d", mon_e.idx), 64'(bus.par_err), 64'(mon_e.perr));
                    check($sformatf("rsp_tags idx%0d", mon_e.idx), 64'(bus.rsp_tags & tag_mask), 64'(exp_tags));
                end
            end
            if (bus.inv_all_req && !bus.inv_busy)
                for (int w = 0; w < WAYS; w++)
                    for (int i = 0; i < DEPTH; i++) model[w][i][TAG_LEN] = 1'b0;
            if (bus.rd_vld && bus.rd_rdy) begin
                push_e.idx  = bus.rd_idx;
                push_e.tag  = bus.rd_tag;
                push_e.hit  = nxt_hit;
                push_e.perr = nxt_perr;
                sb.push_back(push_e);
            end
        end
    end

    task automatic do_write(input logic [6:0] idx, input logic [1:0] way, input logic [20:0] tag, input logic v);
        bus.wr_vld = 1'b1; bus.wr_idx = idx; bus.wr_way = way; bus.wr_tag = tag; bus.wr_valid = v;
        @(posedge clk); #1;
        bus.wr_vld = 1'b0;
    endtask

    task automatic do_lookup(input logic [6:0] idx, input logic [20:0] tag, input logic [1:0] hit, input logic [1:0] perr);
        int guard = 0;
        nxt_hit = hit; nxt_perr = perr;
        bus.rd_vld = 1'b1; bus.rd_idx = idx; bus.rd_tag = tag;
        @(negedge clk);
        while (!bus.rd_rdy && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.rd_rdy) begin
            n_total++;
            $display("FAIL lookup_accept idx%0d: got rd_rdy=0 expected 1 within 300 cycles", idx);
        end
        @(posedge clk); #1;
        bus.rd_vld = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic count_busy(output int n);
        int guard = 0;
        bit seen  = 1'b0;
        n = 0;
        while (guard < 2000) begin
            @(negedge clk);
            guard++;
            if (bus.inv_busy) begin
                n++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
        end
    endtask

    initial begin
        bus.inv_all_req = 1'b0; bus.rd_vld = 1'b0; bus.rd_idx = '0; bus.rd_tag = '0;
        bus.wr_vld = 1'b0; bus.wr_idx = '0; bus.wr_way = '0; bus.wr_tag = '0; bus.wr_valid = 1'b0;
        for (int w = 0; w < WAYS; w++)
            for (int i = 0; i < DEPTH; i++) model[w][i] = '0;

        vecs[0]  = '{1'b1, 7'd5,   2'b10, 21'h1ABCD,  1'b1, 2'b00};
        vecs[1]  = '{1'b0, 7'd5,   2'b00, 21'h1ABCD,  1'b0, 2'b10};
        vecs[2]  = '{1'b0, 7'd5,   2'b00, 21'h1ABCC,  1'b0, 2'b00};
        vecs[3]  = '{1'b1, 7'd5,   2'b01, 21'h1ABCD,  1'b1, 2'b00};
        vecs[4]  = '{1'b0, 7'd5,   2'b00, 21'h1ABCD,  1'b0, 2'b11};
        vecs[5]  = '{1'b1, 7'd5,   2'b11, 21'h00077,  1'b0, 2'b00};
        vecs[6]  = '{1'b0, 7'd5,   2'b00, 21'h00077,  1'b0, 2'b00};
        vecs[7]  = '{1'b1, 7'd6,   2'b00, 21'h00001,  1'b1, 2'b00};
        vecs[8]  = '{1'b0, 7'd6,   2'b00, 21'h00001,  1'b0, 2'b00};
        vecs[9]  = '{1'b1, 7'd127, 2'b11, 21'h1FFFFF, 1'b1, 2'b00};
        vecs[10] = '{1'b0, 7'd127, 2'b00, 21'h1FFFFF, 1'b0, 2'b11};
        vecs[11] = '{1'b1, 7'd0,   2'b01, 21'h00000,  1'b1, 2'b00};
        vecs[12] = '{1'b0, 7'd0,   2'b00, 21'h00000,  1'b0, 2'b01};

        repeat (3) @(negedge clk);
        check("rst_inv_busy", 64'(bus.inv_busy), 64'd0);
        check("rst_rsp_vld",  64'(bus.rsp_vld),  64'd0);
        check("rst_rsp_hit",  64'(bus.rsp_hit),  64'd0);
        check("rst_rsp_tags", 64'(bus.rsp_tags), 64'd0);
        check("rst_par_err",  64'(bus.par_err),  64'd0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        count_busy(cnt);
        check("boot_sweep_cycles", 64'(cnt), 64'd128);
        mon_en = 1'b1;
        @(posedge clk); #1;
        do_lookup(7'd5, 21'h1ABCD, 2'b00, 2'b00);

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].is_wr) do_write(vecs[i].idx, vecs[i].way, vecs[i].tag, vecs[i].v);
            else               do_lookup(vecs[i].idx, vecs[i].tag, vecs[i].hit, 2'b00);
        end

        // Lookup of idx 9 followed by a write to it in the response cycle.
        nxt_hit = 2'b01; nxt_perr = 2'b00;
        bus.rd_vld = 1'b1; bus.rd_idx = 7'd9; bus.rd_tag = 21'h00055;
        @(negedge clk);
        check("fwd_rd_rdy", 64'(bus.rd_rdy), 64'd1);
        @(posedge clk); #1;
        bus.rd_vld = 1'b0;
        bus.wr_vld = 1'b1; bus.wr_idx = 7'd9; bus.wr_way = 2'b01; bus.wr_tag = 21'h00055; bus.wr_valid = 1'b1;
        @(negedge clk);
        check("fwd_rsp_hit", 64'(bus.rsp_hit), 64'h1);
        @(posedge clk); #1;
        bus.wr_vld = 1'b0;

        // Outputs hold the last response while later writes change the array.
        do_write(7'd9, 2'b01, 21'h00066, 1'b1);
        @(negedge clk);
        check("hold_rsp_vld",  64'(bus.rsp_vld), 64'd0);
        check("hold_rsp_hit",  64'(bus.rsp_hit), 64'h1);
        check("hold_rsp_tag0", 64'(bus.rsp_tags[21:0]), 64'h200055);
        @(posedge clk); #1;

        // Write and lookup presented together: write wins, lookup follows.
        nxt_hit = 2'b10; nxt_perr = 2'b00;
        bus.rd_vld = 1'b1; bus.rd_idx = 7'd20; bus.rd_tag = 21'h00003;
        bus.wr_vld = 1'b1; bus.wr_idx = 7'd20; bus.wr_way = 2'b10; bus.wr_tag = 21'h00003; bus.wr_valid = 1'b1;
        @(negedge clk);
        check("simul_rd_rdy_blocked", 64'(bus.rd_rdy), 64'd0);
        @(posedge clk); #1;
        bus.wr_vld = 1'b0;
        @(negedge clk);
        check("simul_rd_rdy_next", 64'(bus.rd_rdy), 64'd1);
        @(posedge clk); #1;
        bus.rd_vld = 1'b0;
        @(posedge clk); #1;

`ifdef D_TAG_PARITY_EN
        do_write(7'd5, 2'b11, 21'h1ABCD, 1'b1);
        dut.tag_mem_q[1][5][0] = ~dut.tag_mem_q[1][5][0];
        model[1][5][0] = ~model[1][5][0];
        do_lookup(7'd5, 21'h1ABCD, 2'b01, 2'b10);
`endif

        for (int i = 0; i < 4; i++) do_write(7'(i), 2'b11, 21'(32'h100 + i), 1'b1);
        do_lookup(7'd2, 21'h00102, 2'b11, 2'b00);

        // Invalidate sweep with a second request issued mid-sweep that must be ignored.
        bus.inv_all_req = 1'b1;
        @(posedge clk); #1;
        bus.inv_all_req = 1'b0;
        cnt = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            bus.inv_all_req = (c == 10);
            if (!bus.rd_rdy) cnt++;
            else if (cnt > 0) break;
        end
        bus.inv_all_req = 1'b0;
        check("inv_sweep_rd_rdy_low", 64'(cnt), 64'd128);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) do_lookup(7'(i), 21'(32'h100 + i), 2'b00, 2'b00);

        // Reset in the middle of a sweep restarts it from index 0.
        bus.inv_all_req = 1'b1;
        @(posedge clk); #1;
        bus.inv_all_req = 1'b0;
        repeat (50) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midsweep_rst_busy", 64'(bus.inv_busy), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        count_busy(cnt);
        check("midsweep_restart_cycles", 64'(cnt), 64'd128);
        @(posedge clk); #1;
        do_lookup(7'd20, 21'h00003, 2'b00, 2'b00);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
